// File: rtl/execute_stage_if.sv
// Execute-stage bus: E pipeline register fields and hazard controls in,
// forwarding taps, condition codes and M pipeline register fields out.
interface execute_stage_if #(
    parameter int N = 64
);
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [N-1:0] E_valA;
    logic [N-1:0] E_valB;
    logic [N-1:0] E_valC;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic         m_exc;
    logic         W_exc;
    logic         M_stall;
    logic         M_bubble;

    logic [N-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_Cnd;
    logic [2:0]   cc;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [N-1:0] M_valE;
    logic [N-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_exc, W_exc, M_stall, M_bubble,
        input  e_valE, e_dstE, e_Cnd, cc,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_exc, W_exc, M_stall, M_bubble,
        output e_valE, e_dstE, e_Cnd, cc,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, 64-bit ALU, condition-code register,
// jXX/cmovXX condition evaluation and the M pipeline register.
module execute_stage #(
    parameter int N = 64
) (
    input logic           clk,
    input logic           rst_n,
    execute_stage_if.slave bus
);
    typedef enum logic [3:0] {
        I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
        I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_XOR = 2'b11
    } alufn_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4
    } stat_e;

    localparam logic [N-1:0] MINUS8 = ~N'(7);
    localparam logic [N-1:0] PLUS8  = N'(8);
    localparam logic [3:0]   RNONE  = 4'hF;

    logic [N-1:0] alu_a, alu_b, alu_r;
    alufn_e       alu_fn;
    logic         alu_of;
    logic [2:0]   alu_flags;
    logic [2:0]   cc_q;
    logic         cnd;
    logic         cc_load;

    logic [2:0]   m_stat_q;
    logic [3:0]   m_icode_q;
    logic         m_cnd_q;
    logic [N-1:0] m_vale_q, m_vala_q;
    logic [3:0]   m_dste_q, m_dstm_q;

    always_comb begin
        alu_a = '0;
        case (bus.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
            I_CALL, I_PUSHQ:              alu_a = MINUS8;
            I_RET, I_POPQ:                alu_a = PLUS8;
            default:                      alu_a = '0;
        endcase

        alu_b = '0;
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valB;
            default: alu_b = '0;
        endcase

        alu_fn = (bus.E_icode == I_OPQ) ? alufn_e'(bus.E_ifun[1:0]) : ALU_ADD;
    end

    // Overflow is judged against the operand signs as the ALU sees them:
    // subtraction is aluB - aluA, so aluB is the reference sign there.
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (alu_fn)
            ALU_ADD: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[N-1] == alu_b[N-1]) && (alu_r[N-1] != alu_a[N-1]);
            end
            ALU_SUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[N-1] != alu_b[N-1]) && (alu_r[N-1] != alu_b[N-1]);
            end
            ALU_AND: alu_r = alu_b & alu_a;
            ALU_XOR: alu_r = alu_b ^ alu_a;
            default: alu_r = '0;
        endcase
        alu_flags = {alu_r[N-1], (alu_r == '0), alu_of};
    end

    // Condition uses the CC value held before this instruction's own update.
    always_comb begin
        cnd = 1'b0;
        case (bus.E_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (cc_q[2] ^ cc_q[0]) | cc_q[1];
            4'h2:    cnd = cc_q[2] ^ cc_q[0];
            4'h3:    cnd = cc_q[1];
            4'h4:    cnd = ~cc_q[1];
            4'h5:    cnd = ~(cc_q[2] ^ cc_q[0]);
            4'h6:    cnd = ~(cc_q[2] ^ cc_q[0]) & ~cc_q[1];
            default: cnd = 1'b0;
        endcase
    end

    assign cc_load = (bus.E_icode == I_OPQ) && (bus.E_stat == STAT_AOK)
                     && !bus.m_exc && !bus.W_exc;

    assign bus.e_valE = alu_r;
    assign bus.e_Cnd  = cnd;
    assign bus.e_dstE = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= 3'b010;
        end else if (cc_load) begin
            cc_q <= alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (!bus.M_stall && bus.M_bubble)) begin
            m_stat_q  <= STAT_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else if (!bus.M_stall) begin
            m_stat_q  <= bus.E_stat;
            m_icode_q <= bus.E_icode;
            m_cnd_q   <= cnd;
            m_vale_q  <= alu_r;
            m_vala_q  <= bus.E_valA;
            m_dste_q  <= bus.e_dstE;
            m_dstm_q  <= bus.E_dstM;
        end
    end

    assign bus.cc      = cc_q;
    assign bus.M_stat  = m_stat_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_Cnd   = m_cnd_q;
    assign bus.M_valE  = m_vale_q;
    assign bus.M_valA  = m_vala_q;
    assign bus.M_dstE  = m_dste_q;
    assign bus.M_dstM  = m_dstm_q;

    stall_bubble_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.M_stall && bus.M_bubble)
    );
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage, sitting between the E pipeline register and the memory stage.
- Selects the ALU operands and function from the decoded instruction fields, and computes valE with the design's 64-bit ALU (function codes 00 add, 01 sub, 10 and, 11 xor; flags ordered {SF,ZF,OF}).
- Holds the architectural condition-code register and evaluates jXX/cmovXX conditions.
- Produces the registered M pipeline register with stall/bubble control.

Parameters:
N, 64, datapath width of valA/valB/valC/valE.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
E_stat  input  3  stat code of instruction in E (1 AOK, 2 HLT, 3 ADR, 4 INS)
E_icode  input  4  instruction code
E_ifun  input  4  function code
E_valA  input  N  register operand A
E_valB  input  N  register operand B
E_valC  input  N  immediate/displacement
E_dstE  input  4  ALU-result destination register (4'hF = none)
E_dstM  input  4  memory-result destination register
m_exc  input  1  memory stage currently has a non-AOK stat
W_exc  input  1  writeback stage has a non-AOK stat
M_stall  input  1  hold M register
M_bubble  input  1  load nop into M register
e_valE  output  N  combinational ALU result, for forwarding
e_dstE  output  4  combinational effective dstE, for forwarding
e_Cnd  output  1  combinational condition result
cc  output  3  current CC register {SF,ZF,OF}
M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  output  3/4/1/N/N/4/4  registered M-stage fields

Behaviour:
- aluA selection:
  - valA for rrmovq (2) and OPq (6).
  - valC for irmovq (3), rmmovq (4), mrmovq (5).
  - -8 for call (8) and pushq (A).
  - +8 for ret (9) and popq (B).
  - 0 otherwise.
- aluB selection:
  - valB for icodes 4,5,6,8,9,A,B.
  - 0 for icodes 2,3 and all others.
- ALU function: E_ifun[1:0] when icode=6, else add.
- valE results:
  - add: aluB+aluA.
  - sub: aluB-aluA.
  - and, xor: bitwise.
  - All results mod 2^N.
- Flags:
  - ZF = (valE==0).
  - SF = valE[N-1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: aluB and aluA signs differ and the result sign differs from aluB.
  - OF = 0 for and/xor.
- CC register: loads computed flags at the clock edge iff icode==6 && E_stat==AOK && !m_exc && !W_exc; otherwise holds. CC is not affected by M_stall or M_bubble.
- e_Cnd is computed from the current (pre-update) CC, by ifun:
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: ~ZF
  - 5: ~(SF^OF)
  - 6: ~(SF^OF)&~ZF
  - 7–F: 0
- e_dstE = 4'hF when icode==2 && !e_Cnd, else E_dstE.
- M register update, by priority at each rising edge:
  1. rst_n low.
  2. M_stall: hold all M fields.
  3. M_bubble: load bubble.
  4. Otherwise load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
- Latency: M fields are valid 1 cycle after E inputs; e_* outputs are 0-cycle combinational.
- Reset and bubble values:
  - Bubble: M_stat=1, M_icode=1, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F.
  - Reset loads the same values as bubble, and sets cc=3'b010 (ZF=1).
  - A reset asserted mid-operation overrides stall, bubble and CC update in that cycle.
- Simultaneous M_stall and M_bubble: stall wins. This case is illegal from the control unit; assertions should flag it.
- Non-AOK E_stat still propagates to M_stat. Only the CC update is suppressed.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> cc=010, M_icode=1, M_stat=1, M_dstE=F, M_valE=0.
- OPq sub with E_ifun=1, valA=5, valB=3 -> e_valE=0xFFFFFFFFFFFFFFFE; next cycle cc=100 (SF=1) and M_valE matches.
- OPq add with valA=0x7FFFFFFFFFFFFFFF, valB=1 -> valE=0x8000000000000000, cc=101. Then jXX ifun=6 -> e_Cnd=1. Then ifun=2 -> e_Cnd=0.
- cmovl (icode 2, ifun 2) with cc=100, E_dstE=3 -> e_dstE=3. Same with cc=010 -> e_dstE=F and M_dstE=F.
- OPq with m_exc=1 -> cc unchanged. pushq valB=0x100 -> M_valE=0xF8, cc unchanged.
- M_stall held for 3 cycles while E changes -> M fields constant. Then M_bubble for 1 cycle -> M_icode=1, M_dstE=F. Reset asserted during the stall -> reset values on the next edge.
